// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared slot type and constants for the rv32i hazard scoreboard
package hazard_pkg;

  // Register address width carried inside each scoreboard slot
  localparam int SLOT_AW = 5;

  // Forward select meaning "use the register file value"
  localparam int FWD_NONE = 0;

  // Register x0 is hard-wired to zero and never creates a dependency
  localparam logic [SLOT_AW-1:0] REG_X0 = '0;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               reg_write;
    logic               is_load;
    logic [SLOT_AW-1:0] rs1;
    logic [SLOT_AW-1:0] rs2;
    logic               uses_rs1;
    logic               uses_rs2;
  } slot_t;

endpackage

// File: rtl/hazard_slot_match.sv
// rtl/hazard_slot_match.sv - compares one in-flight slot against one consumer source register
module hazard_slot_match
  import hazard_pkg::*;
(
  input  logic               slot_valid,
  input  logic               slot_reg_write,
  input  logic               slot_is_load,
  input  logic [SLOT_AW-1:0] slot_rd,
  input  logic [SLOT_AW-1:0] src,
  input  logic               src_used,
  output logic               hit,
  output logic               is_load
);

  // The slot produces a value the consumer really reads; x0 never matches
  assign hit     = slot_valid && slot_reg_write && src_used &&
                   (src != REG_X0) && (slot_rd == src);
  assign is_load = slot_is_load;

endmodule

// File: rtl/rv32i_hazard_scoreboard.sv
// rtl/rv32i_hazard_scoreboard.sv - slot-based stall/flush/forward unit for the pipelined rv32i core
module rv32i_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_SLOTS       = 3,
  parameter int LOAD_READY_SLOT = 2,
  parameter int REG_AW          = 5,
  parameter int FWD_W           = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              valid_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic              uses_rs1_d,
  input  logic              uses_rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              reg_write_d,
  input  logic              is_load_d,
  input  logic              pc_src_e,
  input  logic              mem_busy,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              freeze_back,
  output logic [FWD_W-1:0]  forward_a_e,
  output logic [FWD_W-1:0]  forward_b_e,
  output logic [31:0]       stall_count
);

  slot_t slots [NUM_SLOTS];
  slot_t next_slot0;

  logic [NUM_SLOTS-1:0] e_hit_a, e_ld_a, e_hit_b, e_ld_b;
  logic [NUM_SLOTS-1:0] d_hit_a, d_ld_a, d_hit_b, d_ld_b;

  logic load_hazard;
  logic stall_int, flush_e_int, flush_d_int, freeze_int;
  logic [FWD_W-1:0] fwd_a, fwd_b;

  // Execute view (slot 0 sources) and Decode view against every slot
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_match
    hazard_slot_match u_e_a (
      .slot_valid(slots[k].valid), .slot_reg_write(slots[k].reg_write),
      .slot_is_load(slots[k].is_load), .slot_rd(slots[k].rd),
      .src(slots[0].rs1), .src_used(slots[0].uses_rs1),
      .hit(e_hit_a[k]), .is_load(e_ld_a[k])
    );
    hazard_slot_match u_e_b (
      .slot_valid(slots[k].valid), .slot_reg_write(slots[k].reg_write),
      .slot_is_load(slots[k].is_load), .slot_rd(slots[k].rd),
      .src(slots[0].rs2), .src_used(slots[0].uses_rs2),
      .hit(e_hit_b[k]), .is_load(e_ld_b[k])
    );
    hazard_slot_match u_d_a (
      .slot_valid(slots[k].valid), .slot_reg_write(slots[k].reg_write),
      .slot_is_load(slots[k].is_load), .slot_rd(slots[k].rd),
      .src(rs1_d), .src_used(uses_rs1_d),
      .hit(d_hit_a[k]), .is_load(d_ld_a[k])
    );
    hazard_slot_match u_d_b (
      .slot_valid(slots[k].valid), .slot_reg_write(slots[k].reg_write),
      .slot_is_load(slots[k].is_load), .slot_rd(slots[k].rd),
      .src(rs2_d), .src_used(uses_rs2_d),
      .hit(d_hit_b[k]), .is_load(d_ld_b[k])
    );
  end

  // A Decode consumer must wait while its load producer is too young to forward
  always_comb begin
    load_hazard = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if ((k + 1 < LOAD_READY_SLOT) &&
          ((d_hit_a[k] && d_ld_a[k]) || (d_hit_b[k] && d_ld_b[k])))
        load_hazard = 1'b1;
    end
  end

  // Youngest usable producer wins; young loads are skipped since the stall covers them
  always_comb begin
    fwd_a = FWD_W'(FWD_NONE);
    fwd_b = FWD_W'(FWD_NONE);
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (k != 0 && e_hit_a[k] && !(e_ld_a[k] && k < LOAD_READY_SLOT))
        fwd_a = FWD_W'(k);
      if (k != 0 && e_hit_b[k] && !(e_ld_b[k] && k < LOAD_READY_SLOT))
        fwd_b = FWD_W'(k);
    end
  end

  // A taken branch overrides a load stall; memory back-pressure holds everything
  always_comb begin
    stall_int   = (load_hazard && !pc_src_e) || mem_busy || !ena;
    flush_e_int = (load_hazard || pc_src_e) && !mem_busy && ena;
    flush_d_int = pc_src_e && !mem_busy && ena;
    freeze_int  = mem_busy || !ena;
  end

  // Outputs read as zero for the whole time reset is held
  always_comb begin
    stall_f     = rst && stall_int;
    stall_d     = rst && stall_int;
    flush_e     = rst && flush_e_int;
    flush_d     = rst && flush_d_int;
    freeze_back = rst && freeze_int;
    forward_a_e = (rst && slots[0].valid) ? fwd_a : FWD_W'(FWD_NONE);
    forward_b_e = (rst && slots[0].valid) ? fwd_b : FWD_W'(FWD_NONE);
  end

  // Decode instruction entering Execute, or a bubble when stalled/flushed
  always_comb begin
    next_slot0 = '0;
    if (valid_d && !stall_int && !flush_e_int) begin
      next_slot0.valid     = 1'b1;
      next_slot0.rd        = rd_d;
      next_slot0.reg_write = reg_write_d;
      next_slot0.is_load   = is_load_d;
      next_slot0.rs1       = rs1_d;
      next_slot0.rs2       = rs2_d;
      next_slot0.uses_rs1  = uses_rs1_d;
      next_slot0.uses_rs2  = uses_rs2_d;
    end
  end

  // Shift the in-flight window one stage whenever the back end advances
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_SLOTS; k++) slots[k] <= '0;
    end else if (ena && !mem_busy) begin
      for (int k = NUM_SLOTS - 1; k > 0; k--) slots[k] <= slots[k-1];
      slots[0] <= next_slot0;
    end
  end

  // Saturating count of stalled or frozen enabled cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (ena && (stall_int || freeze_int) && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_rv32i_hazard_scoreboard.sv
// tb/tb_rv32i_hazard_scoreboard.sv - directed bench with behavioural model for two scoreboard configurations
module tb_rv32i_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst, ena, valid_d, uses_rs1_d, uses_rs2_d, reg_write_d, is_load_d, pc_src_e, mem_busy;
  logic [4:0] rs1_d, rs2_d, rd_d;

  logic sf [2];
  logic sd [2];
  logic fd [2];
  logic fe [2];
  logic frz [2];
  logic [1:0] fwa [2];
  logic [1:0] fwb [2];
  logic [31:0] cnt [2];

  int passed = 0;
  int total  = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  rv32i_hazard_scoreboard u_a (
    .clk(clk), .rst(rst), .ena(ena), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d), .rd_d(rd_d), .reg_write_d(reg_write_d),
    .is_load_d(is_load_d), .pc_src_e(pc_src_e), .mem_busy(mem_busy),
    .stall_f(sf[0]), .stall_d(sd[0]), .flush_d(fd[0]), .flush_e(fe[0]), .freeze_back(frz[0]),
    .forward_a_e(fwa[0]), .forward_b_e(fwb[0]), .stall_count(cnt[0])
  );

  rv32i_hazard_scoreboard #(.NUM_SLOTS(4), .LOAD_READY_SLOT(3)) u_b (
    .clk(clk), .rst(rst), .ena(ena), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d), .rd_d(rd_d), .reg_write_d(reg_write_d),
    .is_load_d(is_load_d), .pc_src_e(pc_src_e), .mem_busy(mem_busy),
    .stall_f(sf[1]), .stall_d(sd[1]), .flush_d(fd[1]), .flush_e(fe[1]), .freeze_back(frz[1]),
    .forward_a_e(fwa[1]), .forward_b_e(fwb[1]), .stall_count(cnt[1])
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit v; int rd; bit w; bit ld; int rs1; int rs2; bit u1; bit u2;
  } mslot_t;

  typedef struct {
    bit stall; bit fd; bit fe; bit frz; int fa; int fb;
  } mexp_t;

  mslot_t ms [2][6];
  longint mcnt [2];

  function automatic int cfg_n(int i);
    return (i == 0) ? 3 : 4;
  endfunction

  function automatic int cfg_l(int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic bit prod(mslot_t s, int r);
    return s.v && s.w && (r != 0) && (s.rd == r);
  endfunction

  function automatic int pick(int i, int src, bit used);
    int res = 0;
    bit found = 0;
    if (used) begin
      for (int k = 1; k < cfg_n(i); k++) begin
        if (!found && prod(ms[i][k], src) && !(ms[i][k].ld && k < cfg_l(i))) begin
          res = k;
          found = 1;
        end
      end
    end
    return res;
  endfunction

  function automatic mexp_t model_out(int i);
    mexp_t e;
    bit lh = 0;
    for (int k = 0; k < cfg_n(i); k++) begin
      if (ms[i][k].ld && (k + 1 < cfg_l(i)) &&
          ((uses_rs1_d && prod(ms[i][k], int'(rs1_d))) || (uses_rs2_d && prod(ms[i][k], int'(rs2_d)))))
        lh = 1;
    end
    e.stall = (lh && !pc_src_e) || mem_busy || !ena;
    e.fe    = (lh || pc_src_e) && !mem_busy && ena;
    e.fd    = pc_src_e && !mem_busy && ena;
    e.frz   = mem_busy || !ena;
    e.fa    = ms[i][0].v ? pick(i, ms[i][0].rs1, ms[i][0].u1) : 0;
    e.fb    = ms[i][0].v ? pick(i, ms[i][0].rs2, ms[i][0].u2) : 0;
    if (!rst) begin
      e.stall = 0; e.fe = 0; e.fd = 0; e.frz = 0; e.fa = 0; e.fb = 0;
    end
    return e;
  endfunction

  function automatic bit counts(int i);
    mexp_t e = model_out(i);
    return e.stall || e.frz;
  endfunction

  function automatic mslot_t entering(int i);
    mexp_t e = model_out(i);
    mslot_t s = '{v: 0, rd: 0, w: 0, ld: 0, rs1: 0, rs2: 0, u1: 0, u2: 0};
    if (valid_d && !e.stall && !e.fe)
      s = '{v: 1, rd: int'(rd_d), w: reg_write_d, ld: is_load_d,
            rs1: int'(rs1_d), rs2: int'(rs2_d), u1: uses_rs1_d, u2: uses_rs2_d};
    return s;
  endfunction

  // Model state advances on the same edges as the design
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 6; k++) ms[i][k] <= '{v: 0, rd: 0, w: 0, ld: 0, rs1: 0, rs2: 0, u1: 0, u2: 0};
        mcnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ena && counts(i) && mcnt[i] < 64'hFFFF_FFFF) mcnt[i] <= mcnt[i] + 1;
        if (ena && !mem_busy) begin
          for (int k = 5; k > 0; k--) ms[i][k] <= ms[i][k-1];
          ms[i][0] <= entering(i);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cmp_inst(input int i);
    mexp_t e = model_out(i);
    string p = (i == 0) ? "a" : "b";
    check({p, "_stall_f"}, 64'(sf[i]), 64'(e.stall));
    check({p, "_stall_d"}, 64'(sd[i]), 64'(e.stall));
    check({p, "_flush_d"}, 64'(fd[i]), 64'(e.fd));
    check({p, "_flush_e"}, 64'(fe[i]), 64'(e.fe));
    check({p, "_freeze"}, 64'(frz[i]), 64'(e.frz));
    check({p, "_fwd_a"}, 64'(fwa[i]), 64'(e.fa));
    check({p, "_fwd_b"}, 64'(fwb[i]), 64'(e.fb));
    check({p, "_count"}, 64'(cnt[i]), 64'(mcnt[i]));
  endtask

  // Every cycle, both configurations are compared against the model
  always @(negedge clk) begin
    if (run_cmp) begin
      cmp_inst(0);
      cmp_inst(1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_d(input bit v, input int rd, input bit w, input bit ld,
                       input int r1, input bit u1, input int r2, input bit u2);
    valid_d = v; rd_d = 5'(rd); reg_write_d = w; is_load_d = ld;
    rs1_d = 5'(r1); uses_rs1_d = u1; rs2_d = 5'(r2); uses_rs2_d = u2;
  endtask

  task automatic nop();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    pc_src_e = 0;
    mem_busy = 0;
    repeat (4) tick();
  endtask

  initial begin
    rst = 0; ena = 1; pc_src_e = 0; mem_busy = 0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall_d", 64'(sd[0]), 0);
    check("reset_freeze", 64'(frz[0]), 0);
    check("reset_count", 64'(cnt[0]), 0);
    rst = 1;
    run_cmp = 1;
    tick();

    // back-to-back ALU dependency on x5
    set_d(1, 5, 1, 0, 1, 1, 2, 1); #2;
    check("t1_c0_stall", 64'(sd[0]), 0);
    tick();
    set_d(1, 7, 1, 0, 5, 1, 3, 1); #2;
    check("t1_c1_stall", 64'(sd[0]), 0);
    tick();
    set_d(1, 8, 1, 0, 5, 1, 4, 1); #2;
    check("t1_fwd_a_slot1", 64'(fwa[0]), 1);
    check("t1_c2_stall", 64'(sd[0]), 0);
    tick();
    nop(); #2;
    check("t1_fwd_a_slot2", 64'(fwa[0]), 2);
    check("t1_c3_stall", 64'(sd[0]), 0);
    tick();
    drain();

    // load-use: lw x6 then a reader of x6 through rs2
    set_d(1, 6, 1, 1, 1, 1, 0, 0); #2;
    check("t2_c0_stall", 64'(sd[0]), 0);
    tick();
    set_d(1, 9, 1, 0, 2, 1, 6, 1); #2;
    check("t2_a_stall_f", 64'(sf[0]), 1);
    check("t2_a_stall_d", 64'(sd[0]), 1);
    check("t2_a_flush_e", 64'(fe[0]), 1);
    check("t2_a_flush_d", 64'(fd[0]), 0);
    check("t2_b_stall_1", 64'(sd[1]), 1);
    tick();
    #2;
    check("t2_a_no_stall", 64'(sd[0]), 0);
    check("t2_a_no_flush_e", 64'(fe[0]), 0);
    check("t2_b_stall_2", 64'(sd[1]), 1);
    tick();
    #2;
    check("t2_a_fwd_b", 64'(fwb[0]), 2);
    check("t2_b_no_stall", 64'(sd[1]), 0);
    check("t2_b_count", 64'(cnt[1]), 2);
    tick();
    nop(); #2;
    check("t2_b_fwd_b", 64'(fwb[1]), 3);
    check("t2_a_count", 64'(cnt[0]), 1);
    tick();
    drain();

    // taken branch in the same cycle as a load hazard
    set_d(1, 6, 1, 1, 1, 1, 0, 0); #2;
    tick();
    set_d(1, 9, 1, 0, 6, 1, 0, 0); pc_src_e = 1; #2;
    check("t3_flush_d", 64'(fd[0]), 1);
    check("t3_flush_e", 64'(fe[0]), 1);
    check("t3_stall_d", 64'(sd[0]), 0);
    check("t3_stall_f", 64'(sf[0]), 0);
    tick();
    pc_src_e = 0; set_d(1, 10, 1, 0, 9, 1, 0, 0); #2;
    tick();
    nop(); #2;
    check("t3_slot0_was_bubble", 64'(fwa[0]), 0);
    tick();
    drain();

    // x0 destination never forwards or stalls
    set_d(1, 0, 1, 0, 1, 1, 0, 0); #2;
    tick();
    set_d(1, 11, 1, 0, 0, 1, 0, 1); #2;
    check("t5_x0_no_stall", 64'(sd[0]), 0);
    tick();
    set_d(1, 0, 1, 1, 1, 1, 0, 0); #2;
    check("t5_x0_fwd_a", 64'(fwa[0]), 0);
    check("t5_x0_fwd_b", 64'(fwb[0]), 0);
    tick();
    set_d(1, 6, 1, 1, 0, 1, 0, 0); #2;
    check("t5_x0_load_no_stall", 64'(sd[0]), 0);
    tick();

    // asynchronous reset mid-stream while frozen with a load in flight
    nop(); mem_busy = 1; #2;
    check("t5_pre_freeze", 64'(frz[0]), 1);
    check("t5_pre_count", 64'(cnt[0]), 1);
    rst = 0; #1;
    check("t5_rst_stall_f", 64'(sf[0]), 0);
    check("t5_rst_stall_d", 64'(sd[0]), 0);
    check("t5_rst_freeze", 64'(frz[0]), 0);
    check("t5_rst_flush_e", 64'(fe[0]), 0);
    check("t5_rst_count_a", 64'(cnt[0]), 0);
    check("t5_rst_count_b", 64'(cnt[1]), 0);
    #3;
    rst = 1; mem_busy = 0; set_d(1, 13, 1, 0, 6, 1, 0, 0); #1;
    check("t5_slots_cleared", 64'(sd[0]), 0);
    tick();
    drain();

    // memory busy for three cycles during a taken branch
    set_d(1, 14, 1, 0, 1, 1, 2, 1); pc_src_e = 1; mem_busy = 1;
    for (int c = 0; c < 3; c++) begin
      #2;
      check("t4_freeze", 64'(frz[0]), 1);
      check("t4_stall_f", 64'(sf[0]), 1);
      check("t4_flush_d_held", 64'(fd[0]), 0);
      tick();
    end
    mem_busy = 0; #2;
    check("t4_flush_d", 64'(fd[0]), 1);
    check("t4_flush_e", 64'(fe[0]), 1);
    check("t4_no_stall", 64'(sd[0]), 0);
    check("t4_count", 64'(cnt[0]), 3);
    tick();
    pc_src_e = 0; ena = 0; nop(); #2;
    check("t4_ena0_stall", 64'(sd[0]), 1);
    check("t4_ena0_freeze", 64'(frz[0]), 1);
    tick();
    ena = 1; #2;
    check("t4_ena0_not_counted", 64'(cnt[0]), 3);
    tick();
    drain();

    run_cmp = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rv32i_hazard_scoreboard.md
Name: rv32i_hazard_scoreboard

Overview:
- Parametrised hazard/forwarding unit for the pipelined rv32i core. It replaces the fixed E/M/W hazard logic with a slot-based scoreboard that supports a configurable back-end depth and load latency.
- Tracks every in-flight instruction from Execute to Writeback and generates stall, flush and forward-select signals.
- Also handles memory back-pressure and keeps a stall-cycle counter.

Parameters:
- NUM_SLOTS, 3, back-end stages tracked (slot 0 = E, slot NUM_SLOTS-1 = W); legal range 3..6.
- LOAD_READY_SLOT, 2, first slot from which load data can be forwarded (2 = W); legal range 1..NUM_SLOTS-1.
- REG_AW, 5, register address width.
- FWD_W, $clog2(NUM_SLOTS), forward-select width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- ena  in  1  global enable; 0 freezes all state.
- valid_d  in  1  Decode holds a live instruction.
- rs1_d, rs2_d  in  REG_AW  Decode source registers.
- uses_rs1_d, uses_rs2_d  in  1  the Decode instruction reads rs1/rs2.
- rd_d  in  REG_AW  Decode destination.
- reg_write_d  in  1  the Decode instruction writes rd.
- is_load_d  in  1  the Decode instruction is a load.
- pc_src_e  in  1  taken branch/jump resolved in E.
- mem_busy  in  1  data/instruction memory not ready.
- stall_f, stall_d  out  1  hold the PC and the F/D register.
- flush_d, flush_e  out  1  bubble the F/D and D/E registers.
- freeze_back  out  1  hold the D/E, E/M and M/W registers.
- forward_a_e, forward_b_e  out  FWD_W  0 = register value; k = result from slot k.
- stall_count  out  32  saturating count of cycles with stall_d or freeze_back asserted.

Behaviour:
- Slot contents:
  - Each slot holds {valid, rd, reg_write, is_load, rs1, rs2, uses_rs1, uses_rs2}.
  - Slot 0 is the Execute view; its rs1/rs2 drive forward selection.
- Reset (rst=0, asynchronous):
  - All slots invalid, stall_count=0.
  - All outputs 0.
- Advance condition: ena=1 && mem_busy=0. When it holds, on each rising clk:
  - Slot k shifts into slot k+1; slot NUM_SLOTS-1 retires.
  - Slot 0 loads the Decode fields with valid = valid_d && !stall_d && !flush_e.
  - Otherwise slot 0 loads a bubble.
- Producer match: slot k matches source s iff valid, reg_write, rd==s, s!=0, and the corresponding uses_* bit is set.
- Load-use stall (combinational):
  - Raise load_hazard if any slot k holds a matching load with k+1 < LOAD_READY_SLOT, checked against the Decode sources.
  - Defaults: stall only for a load in slot 0. With LOAD_READY_SLOT=3: stall for a load in slot 0 or slot 1.
- Forwarding:
  - forward_x_e = the smallest k in 1..NUM_SLOTS-1 whose slot matches slot 0's source; 0 if none.
  - A load matched in slot k < LOAD_READY_SLOT is never selected; the stall guarantees this cannot be required.
  - Forward selects are forced to 0 when slot 0 is invalid.
- Register file is write-first: Decode needs no hazard check against slot NUM_SLOTS-1.
- Output equations:
  - stall_f = stall_d = (load_hazard && !pc_src_e) || mem_busy || !ena.
  - flush_e = (load_hazard || pc_src_e) && !mem_busy && ena.
  - flush_d = pc_src_e && !mem_busy && ena.
  - freeze_back = mem_busy || !ena.
- Simultaneous events:
  - pc_src_e together with load_hazard: the flush wins. No stall; both D and E are bubbled.
  - mem_busy together with pc_src_e: everything holds. The flush takes effect in the first cycle mem_busy=0 (pc_src_e stays asserted because E is frozen).
- stall_count:
  - Increments on each clk where stall_d || freeze_back; saturates at 0xFFFF_FFFF.
  - Does not count cycles with ena=0.
- Reset mid-operation: all in-flight slots are discarded immediately; there is no partial retire.
- Latency: all outputs are combinational from the slot state and current inputs; the scoreboard updates with 1-cycle latency.

Decomposition:
- hazard_pkg (shared package) holds:
  - The slot struct typedef.
  - FWD_NONE=0.
  - The constant for reg x0.
- One sub-module, hazard_slot_match: compares one slot against one source register and returns {hit, is_load}. Instantiated 2 × NUM_SLOTS times for the E view and 2 × NUM_SLOTS for the D view.

Test Plan:
- Back-to-back ALU dependency:
  - Stimulus: add x5 (slot 0), then sub using x5 in D. After 1 clk, forward_a_e=1; one clk later, for a further x5 user, forward_a_e=2.
  - Required: no stall at any point.
- Load-use, defaults:
  - Stimulus: lw x6 in slot 0, with D reading x6.
  - Required: stall_f=stall_d=flush_e=1 for exactly 1 cycle. Next cycle the load is in slot 1, no stall; then forward_b_e=2.
- LOAD_READY_SLOT=3, NUM_SLOTS=4:
  - Stimulus: the same sequence as the load-use test.
  - Required: 2 stall cycles; stall_count=2; then forward select=3.
- Branch with load hazard:
  - Stimulus: pc_src_e=1 in the same cycle as load_hazard.
  - Required: flush_d=flush_e=1, stall_d=0; next cycle slot 0 is invalid.
- mem_busy for 3 cycles during a taken branch:
  - Required: freeze_back=1, stall_f=1, flush_d=0 for 3 cycles; flush_d=1 in the 4th cycle; stall_count=3.
- x0 destination and async reset:
  - Stimulus: addi x0 followed by a reader of x0. Then assert rst mid-stream.
  - Required: forward select=0 and no stall for the x0 case. On rst, all outputs are 0 and stall_count=0 immediately, without waiting for a clock edge.
